irq_nest_ctrl: RTL and testbench
================================

Name: irq_nest_ctrl

Overview:
- Parametrised interrupt controller between the external IRQ lines and the pipelined RISC-V CPU core.
- Generalises the fixed 3-line IRQ/IRW scheme to N_IRQ channels.
- Adds per-channel edge/level mode, per-channel and global masking, fixed-priority preemption with a bounded nesting stack, and vector-address generation.
- The CPU takes the request at a pipeline boundary with int_ack and returns from the handler with int_eret.

Parameters:
N_IRQ, 3, number of interrupt channels; channel N_IRQ-1 has the highest priority.
NEST_DEPTH, 3, maximum nested handlers; must be >= 1.
EDGE_MASK, {N_IRQ{1'b1}}, per channel: 1 = rising-edge triggered, 0 = level triggered.
ADDR_WIDTH, 16, width of the vector address.
VEC_BASE, 16'h0000, vector address of channel 0.
VEC_STRIDE, 16'h0004, address step between channel vectors.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  synchronous reset, active-low; sampled on the rising edge of clk.
irq  in  N_IRQ  raw interrupt requests, already synchronous to clk.
irq_en  in  N_IRQ  per-channel enable mask.
global_en  in  1  global interrupt enable.
int_ack  in  1  CPU accepts the current int_id this cycle.
int_eret  in  1  CPU returns from the innermost handler this cycle.
int_req  out  1  an interrupt request is presented to the CPU.
int_id  out  clog2(N_IRQ)  channel number of the presented request.
int_vec  out  ADDR_WIDTH  equals VEC_BASE + int_id*VEC_STRIDE.
irw  out  N_IRQ  in-service bitmask (handlers currently running).
nest_level  out  clog2(NEST_DEPTH+1)  current stack depth.
err  out  1  sticky flag: int_eret received while nest_level==0.

Behaviour:
Reset:
- rst==0 at a rising edge clears all outputs, the pending register, the irq_prev history and the stack to 0.
- Reset overrides any concurrent ack, eret or edge.

Capture:
- Edge channels: pending[i] is set when irq[i]==1 and irq_prev[i]==0.
- Level channels: pending[i] is set every cycle irq[i]==1.
- Capture is independent of the masks. Masked requests stay pending and are served once enabled.

Selection (combinational, from registered state):
- cur_pri is the highest set bit of irw, or -1 if irw==0.
- cand is the highest i such that pending[i] & irq_en[i] and i > cur_pri.

Request register (FSM IDLE/REQ):
- IDLE->REQ when cand is valid, global_en==1 and nest_level<NEST_DEPTH. int_req<=1, int_id<=cand.
- In REQ, if a higher-priority cand appears before the ack, int_id is updated to it and int_req stays 1.
- In REQ, if cand vanishes or global_en drops before the ack, the block returns to IDLE and int_req<=0.
- An ack in REQ returns the block to IDLE.

Latency:
- An edge sampled at clock edge t sets pending at t; int_req goes high after edge t+1.
- After an ack, the next request can appear one cycle later at the earliest.

Ack:
- Effective only when int_req==1; otherwise ignored.
- The block pushes int_id onto the stack, sets irw[int_id], clears pending[int_id] and increments nest_level.
- If a new edge or a still-high level is present on the same channel in that cycle, pending stays set (the capture wins over the clear).

Eret:
- With nest_level>0, the block pops the top id, clears irw[top] and decrements nest_level.
- With nest_level==0 it is ignored and sets err.

Simultaneous int_ack and int_eret:
- The eret is processed and the ack is ignored.
- int_req re-evaluates the next cycle.

Stack full (nest_level==NEST_DEPTH):
- No new request is raised. Pending bits are retained.

Width rules:
- int_vec is computed modulo 2^ADDR_WIDTH.
- irw never holds more than NEST_DEPTH set bits.
- Each channel appears at most once on the stack, because preemption requires strictly higher priority.

Decomposition:
- Shared package irq_pkg holds:
  - the FSM state enum (IDLE, REQ);
  - a priority-encoder function;
  - ID_W = clog2(N_IRQ) and LVL_W = clog2(NEST_DEPTH+1).
- One sub-module, irq_nest_stack: a LIFO of NEST_DEPTH x ID_W entries with push, pop, top, level, full and empty.
- The top level contains capture, selection, the FSM and vector generation.

Test Plan:
1. Reset: hold rst=0 for 2 cycles while irq=3'b111 -> int_req=0, irw=0, nest_level=0, err=0. Release rst -> int_req=1 with int_id=2, two cycles after release.
2. Nesting: irq[0] pulse, ack (irw=3'b001, int_vec=16'h0000); then irq[2] pulse -> int_req with int_id=2 and int_vec=16'h0008; ack gives irw=3'b101, nest_level=2; eret twice gives irw=3'b001 then 0.
3. No preemption: with irq[2] in service, pulse irq[1] -> int_req stays 0. After eret, int_req=1 with int_id=1.
4. Masking and full stack: pulse irq[1] with irq_en=3'b101 -> no request. Then set irq_en[1]=1 -> request with int_id=1. Separately, with NEST_DEPTH=1 and ch0 in service, pulse irq[2] -> no request until eret.
5. Corner cases:
   - int_ack and int_eret asserted together -> pop only; irw loses its top bit; pending is unchanged.
   - eret with an empty stack -> err=1, held until reset.
   - Level channel held high through the ack -> pending is re-set; after the eret, a new request appears.

Source files
------------

// File: rtl/irq_nest_ctrl_pkg.sv
// Shared types, widths and helpers for the nested interrupt controller.
// Package defaults describe the 3-channel, 3-deep configuration.
package irq_pkg;

    localparam int N_IRQ_DEF      = 3;
    localparam int NEST_DEPTH_DEF = 3;
    localparam int ID_W           = $clog2(N_IRQ_DEF);
    localparam int LVL_W          = $clog2(NEST_DEPTH_DEF + 1);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    // Minimum one bit so single-channel builds still get a usable id field.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Index of the highest set bit, -1 when nothing is set.
    function automatic int prio_enc(input logic [31:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/irq_nest_ctrl_if.sv
// CPU-side request/acknowledge bundle of the interrupt controller.
// master = controller, slave = CPU core.
interface irq_nest_ctrl_if #(
    parameter int ID_W       = irq_pkg::ID_W,
    parameter int ADDR_WIDTH = 16
);

    logic                  int_req;
    logic [ID_W-1:0]       int_id;
    logic [ADDR_WIDTH-1:0] int_vec;
    logic                  int_ack;
    logic                  int_eret;

    modport master (
        output int_req,
        output int_id,
        output int_vec,
        input  int_ack,
        input  int_eret
    );

    modport slave (
        input  int_req,
        input  int_id,
        input  int_vec,
        output int_ack,
        output int_eret
    );

endinterface

// File: rtl/irq_nest_stack.sv
// LIFO of in-service channel ids for nested handlers.
// Pop wins over push when both are requested.
module irq_nest_stack
    import irq_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int IW    = 2,
    parameter int LW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [IW-1:0] din,
    output logic [IW-1:0] top,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    logic [IW-1:0] mem [DEPTH];
    logic [LW-1:0] lvl;

    assign full  = (int'(lvl) == DEPTH);
    assign empty = (lvl == '0);
    assign level = lvl;

    // Storage and depth counter; entries are cleared on reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lvl <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (pop && !empty) begin
            lvl <= lvl - 1'b1;
        end else if (push && !full) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (int'(lvl) == i) mem[i] <= din;
            end
            lvl <= lvl + 1'b1;
        end
    end

    // Innermost entry, zero when the stack is empty.
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(lvl) == i + 1) top = mem[i];
        end
    end

endmodule

// File: rtl/irq_nest_ctrl.sv
// Nested fixed-priority interrupt controller: capture, selection,
// request FSM and vector generation around the in-service stack.
module irq_nest_ctrl
    import irq_pkg::*;
#(
    parameter int                    N_IRQ      = 3,
    parameter int                    NEST_DEPTH = 3,
    parameter logic [N_IRQ-1:0]      EDGE_MASK  = {N_IRQ{1'b1}},
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] VEC_BASE   = '0,
    parameter logic [ADDR_WIDTH-1:0] VEC_STRIDE = ADDR_WIDTH'(4)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_IRQ-1:0]              irq,
    input  logic [N_IRQ-1:0]              irq_en,
    input  logic                          global_en,
    irq_nest_ctrl_if.master               cpu,
    output logic [N_IRQ-1:0]              irw,
    output logic [width_of(NEST_DEPTH+1)-1:0] nest_level,
    output logic                          err
);

    localparam int IW = width_of(N_IRQ);
    localparam int LW = width_of(NEST_DEPTH + 1);

    state_t           state;
    state_t           state_nxt;
    logic [IW-1:0]    id_q;
    logic [IW-1:0]    id_nxt;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] irq_prev;
    logic [N_IRQ-1:0] irw_q;
    logic [N_IRQ-1:0] set_vec;
    logic [N_IRQ-1:0] clr_vec;
    logic [N_IRQ-1:0] above;
    logic [N_IRQ-1:0] elig;
    logic             err_q;
    logic             ack_eff;
    logic             pop_eff;
    logic             cand_ok;
    int               cur_pri;
    int               cand;
    logic [IW-1:0]    top;
    logic [LW-1:0]    level;
    logic             full;
    logic             empty;

    // An eret in the same cycle cancels the ack.
    assign ack_eff = (state == REQ) && cpu.int_ack && !cpu.int_eret;
    assign pop_eff = cpu.int_eret && !empty;

    assign set_vec = (irq & ~irq_prev & EDGE_MASK) | (irq & ~EDGE_MASK);

    // Candidate must outrank every running handler.
    always_comb begin
        clr_vec = '0;
        if (ack_eff) clr_vec[id_q] = 1'b1;
        cur_pri = prio_enc(32'(irw_q));
        above   = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            above[i] = (i > cur_pri);
        end
        elig    = pending & irq_en & above;
        cand    = prio_enc(32'(elig));
        cand_ok = (elig != '0) && global_en && !full;
    end

    // Request FSM next-state: raise, retarget or withdraw the request.
    always_comb begin
        state_nxt = state;
        id_nxt    = id_q;
        unique case (state)
            IDLE: begin
                if (cand_ok) begin
                    state_nxt = REQ;
                    id_nxt    = IW'(cand);
                end
            end
            REQ: begin
                if (ack_eff) begin
                    state_nxt = IDLE;
                end else if (cand_ok) begin
                    id_nxt = IW'(cand);
                end else begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    // Request FSM state and presented id.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            id_q  <= '0;
        end else begin
            state <= state_nxt;
            id_q  <= id_nxt;
        end
    end

    // Pending capture; a fresh capture beats the ack clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending  <= '0;
            irq_prev <= '0;
        end else begin
            pending  <= (pending & ~clr_vec) | set_vec;
            irq_prev <= irq;
        end
    end

    // In-service mask and sticky underflow flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            irw_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (pop_eff) begin
                irw_q[top] <= 1'b0;
            end else if (ack_eff) begin
                irw_q[id_q] <= 1'b1;
            end
            if (cpu.int_eret && empty) err_q <= 1'b1;
        end
    end

    irq_nest_stack #(
        .DEPTH (NEST_DEPTH),
        .IW    (IW),
        .LW    (LW)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (ack_eff),
        .pop   (cpu.int_eret),
        .din   (id_q),
        .top   (top),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    assign cpu.int_req = (state == REQ);
    assign cpu.int_id  = id_q;
    assign cpu.int_vec = VEC_BASE + ADDR_WIDTH'(id_q) * VEC_STRIDE;
    assign irw         = irw_q;
    assign nest_level  = level;
    assign err         = err_q;

endmodule

// File: tb/tb_irq_nest_ctrl.sv
// Scoreboard bench for irq_nest_ctrl: two configurations share the
// stimulus, each checked against its own behavioural model.
module tb_irq_nest_ctrl;

    typedef struct {
        bit req;
        int id;
        int vec;
        int irw;
        int lvl;
        bit err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] irq;
    logic [2:0] irq_en;
    logic       global_en;
    logic       ack;
    logic       eret;

    logic [2:0] irw_a;
    logic [2:0] irw_b;
    logic [1:0] lvl_a;
    logic [0:0] lvl_b;
    logic       err_a;
    logic       err_b;

    int checks = 0;
    int errors = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;

    bit m_pend[2][3];
    bit m_prev[2][3];
    int m_stk[2][4];
    int m_sz[2];
    bit m_req[2];
    int m_id[2];
    bit m_err[2];

    always #5 clk = ~clk;

    irq_nest_ctrl_if #(.ID_W(2), .ADDR_WIDTH(16)) cpu_a ();
    irq_nest_ctrl_if #(.ID_W(2), .ADDR_WIDTH(16)) cpu_b ();

    assign cpu_a.int_ack  = ack;
    assign cpu_a.int_eret = eret;
    assign cpu_b.int_ack  = ack;
    assign cpu_b.int_eret = eret;

    irq_nest_ctrl #(
        .N_IRQ      (3),
        .NEST_DEPTH (3),
        .EDGE_MASK  (3'b111),
        .ADDR_WIDTH (16),
        .VEC_BASE   (16'h0000),
        .VEC_STRIDE (16'h0004)
    ) dut_a (
        .clk        (clk),
        .rst        (rst),
        .irq        (irq),
        .irq_en     (irq_en),
        .global_en  (global_en),
        .cpu        (cpu_a),
        .irw        (irw_a),
        .nest_level (lvl_a),
        .err        (err_a)
    );

    irq_nest_ctrl #(
        .N_IRQ      (3),
        .NEST_DEPTH (1),
        .EDGE_MASK  (3'b110),
        .ADDR_WIDTH (16),
        .VEC_BASE   (16'h0000),
        .VEC_STRIDE (16'h8000)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .irq        (irq),
        .irq_en     (irq_en),
        .global_en  (global_en),
        .cpu        (cpu_b),
        .irw        (irw_b),
        .nest_level (lvl_b),
        .err        (err_b)
    );

    // Reference: cfg 0 = 3 deep, all edge, stride 4;
    // cfg 1 = 1 deep, ch0 level, stride 0x8000.
    task automatic model_step(input int k);
        int   depth;
        int   stride;
        int   cur;
        int   cand;
        int   ack_id;
        bit   do_ack;
        bit   ok;
        bit   lvl_mode;
        bit   set;
        exp_t e;
        depth  = (k == 0) ? 3 : 1;
        stride = (k == 0) ? 4 : 'h8000;
        if (!rst) begin
            m_sz[k]  = 0;
            m_req[k] = 0;
            m_id[k]  = 0;
            m_err[k] = 0;
            for (int i = 0; i < 3; i++) begin
                m_pend[k][i] = 0;
                m_prev[k][i] = 0;
            end
        end else begin
            cur = -1;
            for (int j = 0; j < m_sz[k]; j++) begin
                if (m_stk[k][j] > cur) cur = m_stk[k][j];
            end
            cand = -1;
            for (int i = 2; i >= 0; i--) begin
                if (cand < 0 && m_pend[k][i] && irq_en[i] && i > cur)
                    cand = i;
            end
            do_ack = ack && m_req[k] && !eret;
            ok     = (cand >= 0) && global_en && (m_sz[k] < depth);
            ack_id = m_id[k];
            if (do_ack) begin
                m_req[k] = 0;
            end else begin
                m_req[k] = ok;
                if (ok) m_id[k] = cand;
            end
            if (eret) begin
                if (m_sz[k] > 0) m_sz[k] = m_sz[k] - 1;
                else m_err[k] = 1;
            end else if (do_ack) begin
                m_stk[k][m_sz[k]] = ack_id;
                m_sz[k] = m_sz[k] + 1;
            end
            for (int i = 0; i < 3; i++) begin
                lvl_mode = (k == 1) && (i == 0);
                set = irq[i] && (lvl_mode || !m_prev[k][i]);
                if (do_ack && ack_id == i) m_pend[k][i] = 0;
                if (set) m_pend[k][i] = 1;
                m_prev[k][i] = irq[i];
            end
        end
        e.req = m_req[k];
        e.id  = m_id[k];
        e.vec = (m_id[k] * stride) % 65536;
        e.irw = 0;
        for (int j = 0; j < m_sz[k]; j++) begin
            e.irw = e.irw | (1 << m_stk[k][j]);
        end
        e.lvl = m_sz[k];
        e.err = m_err[k];
        if (k == 0) qa.push_back(e);
        else qb.push_back(e);
    endtask

    task automatic cmp(input string nm, input exp_t e, input bit req,
                       input int id, input int vec, input int irw,
                       input int lvl, input bit er);
        checks++;
        if (req != e.req || (e.req && id != e.id) || vec != e.vec ||
            irw != e.irw || lvl != e.lvl || er != e.err) begin
            errors++;
            $display("FAIL %s t=%0t got req=%0d id=%0d vec=%h irw=%b lvl=%0d err=%0d want req=%0d id=%0d vec=%h irw=%b lvl=%0d err=%0d",
                     nm, $time, req, id, vec, irw[2:0], lvl, er,
                     e.req, e.id, e.vec, e.irw[2:0], e.lvl, e.err);
        end
    endtask

    // Monitor: compare each presented output set with the oldest expectation.
    always @(negedge clk) begin
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            cmp("cfgA", ea, cpu_a.int_req, int'(cpu_a.int_id),
                int'(cpu_a.int_vec), int'(irw_a), int'(lvl_a), err_a);
        end
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            cmp("cfgB", eb, cpu_b.int_req, int'(cpu_b.int_id),
                int'(cpu_b.int_vec), int'(irw_b), int'(lvl_b), err_b);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic cyc(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst  = 1'b0;
        irq  = '0;
        ack  = 1'b0;
        eret = 1'b0;
        cyc(2);
        rst  = 1'b1;
    endtask

    task automatic pulse(input int ch);
        irq[ch] = 1'b1;
        tick();
        irq[ch] = 1'b0;
    endtask

    task automatic ack1();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic eret1();
        eret = 1'b1;
        tick();
        eret = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        irq       = 3'b111;
        irq_en    = 3'b111;
        global_en = 1'b1;
        ack       = 1'b0;
        eret      = 1'b0;

        // reset with all lines high, then release
        cyc(2);
        rst = 1'b1;
        cyc(3);

        // nesting ch0 then ch2
        do_reset();
        pulse(0); cyc(2); ack1(); cyc(1);
        pulse(2); cyc(2); ack1(); cyc(1);
        eret1(); cyc(1); eret1(); cyc(2);

        // lower priority must wait for eret
        do_reset();
        pulse(2); cyc(2); ack1();
        pulse(1); cyc(3);
        eret1(); cyc(2); ack1(); eret1(); cyc(1);

        // masked channel served once enabled
        do_reset();
        irq_en = 3'b101;
        pulse(1); cyc(3);
        irq_en = 3'b111;
        cyc(2); ack1(); eret1(); cyc(1);

        // global enable dropped while requesting
        do_reset();
        pulse(1); cyc(2);
        global_en = 1'b0; cyc(2);
        global_en = 1'b1; cyc(2); ack1(); eret1(); cyc(1);

        // full stack on the 1-deep configuration
        do_reset();
        pulse(0); cyc(2); ack1();
        pulse(2); cyc(3);
        eret1(); cyc(2); ack1(); cyc(1); eret1(); cyc(1);

        // ack and eret together, then eret underflow
        do_reset();
        pulse(0); cyc(2); ack1();
        pulse(2); cyc(2);
        ack = 1'b1; eret = 1'b1; tick();
        ack = 1'b0; eret = 1'b0; cyc(2);
        eret1(); eret1(); eret1(); cyc(3);

        // level channel held through ack
        do_reset();
        irq[0] = 1'b1; cyc(2); ack1(); cyc(2);
        eret1(); cyc(2);
        irq[0] = 1'b0; cyc(1); ack1(); eret1(); cyc(2);

        // randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 2) == 0) irq = 3'($urandom_range(0, 7));
            irq_en    = ($urandom_range(0, 7) != 0) ? 3'b111
                                                    : 3'($urandom_range(0, 7));
            global_en = ($urandom_range(0, 9) != 0);
            ack       = ($urandom_range(0, 2) == 0);
            eret      = ($urandom_range(0, 5) == 0);
            tick();
        end
        ack  = 1'b0;
        eret = 1'b0;
        cyc(2);
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
